// File: rtl/pipe_catch_pkg.sv
// Shared width helpers for the pipeline catch buffer.
package pipe_catch_pkg;

  function automatic int cnt_w(int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointers carry one extra wrap bit above the index.
  function automatic int ptr_w(int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_DEPTH = 16;
  localparam int DEF_PTR_W = ptr_w(DEF_DEPTH);

endpackage

// File: rtl/pipe_catch_fifo_if.sv
// Producer/pipeline/consumer signal bundle of the catch buffer.
interface pipe_catch_fifo_if
  import pipe_catch_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
);
  logic                      issue_ready_o;
  logic                      issue_i;
  logic                      pipe_valid_i;
  logic [DATA_W-1:0]         pipe_data_i;
  logic                      out_valid_o;
  logic [DATA_W-1:0]         out_data_o;
  logic                      out_ready_i;
  logic [cnt_w(DEPTH)-1:0]   count_o;
  logic                      err_o;

  modport slave (
    output issue_ready_o, out_valid_o, out_data_o, count_o, err_o,
    input  issue_i, pipe_valid_i, pipe_data_i, out_ready_i
  );

  modport master (
    input  issue_ready_o, out_valid_o, out_data_o, count_o, err_o,
    output issue_i, pipe_valid_i, pipe_data_i, out_ready_i
  );
endinterface

// File: rtl/pipe_catch_mem.sv
// Simple dual-port storage with registered, write-through read port.
module pipe_catch_mem #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // A push into an empty buffer lands on the read address; forward it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                rdata_q <= '0;
    else if (we_i && (waddr_i == raddr_i))     rdata_q <= wdata_i;
    else if (re_i)                             rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/pipe_catch_fifo.sv
// Credit-gated catch buffer behind a fixed-latency, non-stallable pipeline.
// Optional sticky error flag and assertions: PIPE_CATCH_FIFO_ERR_CHECK_EN.
module pipe_catch_fifo
  import pipe_catch_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int LATENCY = 8,
  parameter int DEPTH   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_catch_fifo_if.slave bus
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam int IW = PW - 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("LATENCY must be at least 1");
  end

  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] rsv_q, rsv_d;
  logic          empty, full, iss, pop, push;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[IW-1:0] == rp_q[IW-1:0]) && (wp_q[IW] != rp_q[IW]);

  assign bus.issue_ready_o = (rsv_q != CW'(DEPTH));
  assign iss  = bus.issue_i & bus.issue_ready_o;
  assign pop  = !empty & bus.out_ready_i;
  // A same-cycle pop frees the head slot, so a full buffer can still accept.
  assign push = bus.pipe_valid_i & (!full | pop);

  always_comb begin
    wp_d  = wp_q + PW'(push);
    rp_d  = rp_q + PW'(pop);
    rsv_d = rsv_q + CW'(iss) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      rsv_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      rsv_q <= rsv_d;
    end
  end

  pipe_catch_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (push),
    .waddr_i (wp_q[IW-1:0]),
    .wdata_i (bus.pipe_data_i),
    .re_i    (pop),
    .raddr_i (rp_d[IW-1:0]),
    .rdata_o (bus.out_data_o)
  );

  assign bus.out_valid_o = !empty;
  assign bus.count_o     = CW'(wp_q - rp_q);

`ifdef PIPE_CATCH_FIFO_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q
          | (bus.pipe_valid_i & full & !pop)
          | (bus.issue_i & !bus.issue_ready_o);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.err_o = err_q;

  always @(posedge clk) begin
    if (rst_n) begin
      assert (rsv_q <= CW'(DEPTH));
      assert (!(bus.pipe_valid_i && (rsv_q == bus.count_o)));
    end
  end
`else
  assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_catch_fifo.sv
// Directed bench: models the fixed-latency pipeline and checks the catch buffer.
module tb_pipe_catch_fifo;
  localparam int DW  = 64;
  localparam int LAT = 8;
  localparam int DEP = 16;
`ifdef PIPE_CATCH_FIFO_ERR_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;

  logic          sr_v [LAT];
  logic [DW-1:0] sr_d [LAT];
  logic [DW-1:0] issue_data;
  logic [DW-1:0] exp_q [$];

  pipe_catch_fifo_if #(.DATA_W(DW), .DEPTH(DEP)) bus ();

  pipe_catch_fifo #(.DATA_W(DW), .LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // One clock: record the accepted issue, advance the delay line, present its tail.
  task automatic tick(output logic iss_now);
    iss_now = bus.issue_i & bus.issue_ready_o;
    @(posedge clk);
    #1;
    for (int k = LAT - 1; k > 0; k--) begin
      sr_v[k] = sr_v[k-1];
      sr_d[k] = sr_d[k-1];
    end
    sr_v[0] = iss_now;
    sr_d[0] = issue_data;
    bus.pipe_valid_i = sr_v[LAT-1];
    bus.pipe_data_i  = sr_d[LAT-1];
  endtask

  task automatic ticks(input int n);
    logic dummy;
    for (int i = 0; i < n; i++) tick(dummy);
  endtask

  task automatic clear_pipe();
    for (int k = 0; k < LAT; k++) begin
      sr_v[k] = 1'b0;
      sr_d[k] = '0;
    end
    bus.pipe_valid_i = 1'b0;
    bus.pipe_data_i  = '0;
  endtask

  initial begin
    logic    iss;
    int      expn;
    int      issued;
    checks = 0;
    passes = 0;
    rst_n = 1'b0;
    bus.issue_i = 1'b0;
    bus.out_ready_i = 1'b0;
    issue_data = '0;
    clear_pipe();

    #12;
    check("rst_valid", bus.out_valid_o, 1'b0);
    check("rst_data",  bus.out_data_o, '0);
    check("rst_count", bus.count_o, '0);
    check("rst_err",   bus.err_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", bus.issue_ready_o, 1'b1);

    // Fill: 16 credits taken back-to-back, data 5..20.
    for (int i = 0; i < DEP; i++) begin
      check("fill_ready", bus.issue_ready_o, 1'b1);
      bus.issue_i = 1'b1;
      issue_data = DW'(5 + i);
      tick(iss);
    end
    bus.issue_i = 1'b0;
    check("fill_ready_drop", bus.issue_ready_o, 1'b0);
    ticks(10);
    check("fill_count", bus.count_o, 5'd16);
    check("fill_valid", bus.out_valid_o, 1'b1);
    check("fill_head",  bus.out_data_o, 64'h5);
    check("fill_err",   bus.err_o, 1'b0);

    // Single pop returns one credit on the next cycle.
    bus.out_ready_i = 1'b1;
    tick(iss);
    bus.out_ready_i = 1'b0;
    check("pop_ready", bus.issue_ready_o, 1'b1);
    check("pop_count", bus.count_o, 5'd15);
    check("pop_head",  bus.out_data_o, 64'h6);
    bus.issue_i = 1'b1;
    issue_data = 64'h77;
    tick(iss);
    bus.issue_i = 1'b0;
    check("reissue_ready", bus.issue_ready_o, 1'b0);
    ticks(10);
    check("reissue_count", bus.count_o, 5'd16);
    check("reissue_err",   bus.err_o, 1'b0);
    check("hold_head",     bus.out_data_o, 64'h6);

`ifndef PIPE_CATCH_FIFO_ERR_CHECK_EN
    // Stray result into a full buffer must be dropped.
    bus.pipe_valid_i = 1'b1;
    bus.pipe_data_i  = 64'hDEAD;
    tick(iss);
    check("ovf_count", bus.count_o, 5'd16);
    check("ovf_err",   bus.err_o, 1'b0);
    check("ovf_head",  bus.out_data_o, 64'h6);
`endif

    // Issue without a credit is ignored.
    bus.issue_i = 1'b1;
    issue_data = 64'h99;
    tick(iss);
    bus.issue_i = 1'b0;
    check("noc_ready", bus.issue_ready_o, 1'b0);
    check("noc_err",   bus.err_o, ERR_ON);
    ticks(10);
    check("noc_count", bus.count_o, 5'd16);

    bus.out_ready_i = 1'b1;
    tick(iss);
    bus.out_ready_i = 1'b0;
    check("pop2_ready", bus.issue_ready_o, 1'b1);
    bus.issue_i = 1'b1;
    issue_data = 64'h88;
    tick(iss);
    bus.issue_i = 1'b0;
    check("reissue2_ready", bus.issue_ready_o, 1'b0);
    ticks(10);
    check("reissue2_count", bus.count_o, 5'd16);

    // Drain: 7..20, then 0x77 and 0x88; the stray 0xDEAD must not appear.
    for (int i = 7; i <= 20; i++) exp_q.push_back(DW'(i));
    exp_q.push_back(64'h77);
    exp_q.push_back(64'h88);
    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (bus.out_valid_o) check("drain_data", bus.out_data_o, exp_q.pop_front());
      tick(iss);
    end
    check("drain_left",  DW'(exp_q.size()), '0);
    check("drain_count", bus.count_o, '0);
    check("drain_ready", bus.issue_ready_o, 1'b1);
    check("drain_valid", bus.out_valid_o, 1'b0);

    // Streaming 0..99 with the consumer always ready.
    expn = 0;
    issued = 0;
    for (int c = 0; c < 200 && expn < 100; c++) begin
      if (bus.out_valid_o) begin
        check("stream_data", bus.out_data_o, DW'(expn));
        expn++;
      end
      bus.issue_i = (issued < 100);
      issue_data = DW'(issued);
      tick(iss);
      if (iss) issued++;
    end
    bus.issue_i = 1'b0;
    bus.out_ready_i = 1'b0;
    check("stream_len",   DW'(expn), DW'(100));
    check("stream_count", bus.count_o, '0);
    check("stream_err",   bus.err_o, ERR_ON);

    // Reset with 5 stored and 3 in flight.
    for (int i = 0; i < 8; i++) begin
      bus.issue_i = 1'b1;
      issue_data = DW'(256 + i);
      tick(iss);
    end
    bus.issue_i = 1'b0;
    ticks(5);
    check("pre_rst_count", bus.count_o, 5'd5);
    check("pre_rst_head",  bus.out_data_o, DW'(256));
    #2;
    rst_n = 1'b0;
    clear_pipe();
    #1;
    check("arst_valid", bus.out_valid_o, 1'b0);
    check("arst_data",  bus.out_data_o, '0);
    check("arst_count", bus.count_o, '0);
    check("arst_err",   bus.err_o, 1'b0);
    check("arst_ready", bus.issue_ready_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", bus.issue_ready_o, 1'b1);
    check("post_rst_count", bus.count_o, '0);
    ticks(12);
    check("post_rst_idle", bus.count_o, '0);
    check("post_rst_valid", bus.out_valid_o, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
